// File: rtl/router_pkg.sv
// Shared router definitions: field widths, the packet header layout and the transmit FSM states.
// The receive side imports the same package, so header layout changes land in one place.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int LEN_W     = 6;
    localparam int NUM_PORTS = 3;
    localparam int MAX_LEN   = 63;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/tx_pkt_buffer.sv
// Synchronous FIFO that holds one packet payload so it can be sent without bubbles.
// A pop loads the head byte into rd_data on the same edge; DEPTH must be a power of two.
module tx_pkt_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && (count != CW'(DEPTH));
    assign do_rd = rd_en && (count != '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Overflowing writes and underflowing reads are dropped rather than corrupting the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet transmitter feeding the router input port: header, payload, parity.
// The payload is fully buffered first because a low pkt_valid is how the router sees end-of-payload.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 63,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_done,
    output logic              req_err
);

    localparam int BUF_DEPTH = MAX_LEN + 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam int GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    tx_state_e         state_q, state_d;
    hdr_t              hdr_q, hdr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic              err_d;
    logic              done_d;
    logic              wr_en;
    logic              rd_en;
    logic              last_byte;
    logic [DATA_W-1:0] buf_data;
    logic [CNT_W-1:0]  buf_count;

    tx_pkt_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (pl_data),
        .rd_en   (rd_en),
        .rd_data (buf_data),
        .count   (buf_count)
    );

    assign last_byte = (cnt_q == hdr_q.len - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hdr_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            parity_q <= '0;
            tx_done  <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            parity_q <= parity_d;
            tx_done  <= done_d;
            req_err  <= err_d;
        end
    end

    // A busy cycle leaves every register untouched, which is what keeps the wire bit-stable.
    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        parity_d = parity_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_addr == ADDR_W'(NUM_PORTS) || req_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        hdr_d   = '{len: req_len, addr: req_addr};
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (pl_valid) begin
                    wr_en = 1'b1;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = ST_HEADER;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_HEADER: begin
                parity_d = DATA_W'(hdr_q);
                if (!busy) begin
                    rd_en   = (buf_count != '0);
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!busy) begin
                    parity_d = parity_q ^ buf_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        rd_en = (buf_count != '0);
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wire outputs select between registers by state, so they move only on transfers or state changes.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        pl_ready  = (state_q == ST_LOAD);
        pkt_valid = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
        data_out  = '0;
        case (state_q)
            ST_HEADER:  data_out = DATA_W'(hdr_q);
            ST_PAYLOAD: data_out = buf_data;
            ST_PARITY:  data_out = parity_q;
            default:    data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed and randomized packets checked against a queue-based packet model.
// A negedge monitor reconstructs what the router would have received.
module tb_router_pkt_tx;

    localparam int GAP_CYC = 2;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       req_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl_bytes [64];
    logic [7:0] rx_q [$];
    logic [7:0] par_q [$];
    int         done_cnt;
    int         err_cnt;
    int         hold_viol;
    int         hdr_cycles;
    int         gap_count;
    logic       in_pkt;
    logic       gap_run;
    logic       prev_busy;
    logic       prev_active;
    logic       prev_pv;
    logic [7:0] prev_data;

    router_pkt_tx #(
        .DATA_W  (8),
        .MAX_LEN (63),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Router-side view: a byte moves on the next posedge when busy is low; the first
    // non-valid byte after valid ones is the parity byte.
    always @(negedge clk) begin
        if (rst) begin
            in_pkt    = 1'b0;
            prev_busy = 1'b0;
            gap_run   = 1'b0;
        end else begin
            if (prev_busy && prev_active && (pkt_valid !== prev_pv || data_out !== prev_data))
                hold_viol++;
            prev_active = pkt_valid || in_pkt;
            prev_busy   = busy;
            prev_pv     = pkt_valid;
            prev_data   = data_out;
            if (tx_done) done_cnt++;
            if (req_err) err_cnt++;
            if (pkt_valid && rx_q.size() == 0) hdr_cycles++;
            if (!busy && pkt_valid) begin
                rx_q.push_back(data_out);
                in_pkt = 1'b1;
            end else if (!busy && in_pkt) begin
                par_q.push_back(data_out);
                in_pkt = 1'b0;
            end
            if (tx_done) begin
                gap_run   = 1'b1;
                gap_count = 1;
            end else if (gap_run) begin
                if (req_ready) gap_run = 1'b0;
                else gap_count++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // mode: 0 no busy, 1 busy for 4 header cycles, 2 random busy and payload gaps, 3 reset mid-payload
    task automatic applyStimulus(input logic [1:0] addr, input logic [5:0] len, input int mode);
        logic [7:0] exp_q [$];
        logic [7:0] exp_par;
        bit         legal;
        bit         accepted;
        bit         taken;
        int         load_fail;
        int         held;

        legal = (addr != 2'd3) && (len != 6'd0);
        exp_q.push_back({len, addr});
        for (int i = 0; i < int'(len); i++) exp_q.push_back(pl_bytes[i]);
        exp_par = 8'h00;
        foreach (exp_q[i]) exp_par ^= exp_q[i];

        rx_q.delete();
        par_q.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        hold_viol  = 0;
        hdr_cycles = 0;
        gap_count  = 0;
        load_fail  = 0;
        held       = 0;
        busy       = 1'b0;

        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        accepted  = 1'b0;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            accepted = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        checkOutput("req_accepted", 32'(accepted), 1);

        if (!legal) begin
            @(negedge clk);
            checkOutput("req_err_pulse", 32'(req_err), 1);
            checkOutput("req_ready_after_err", 32'(req_ready), 1);
            repeat (5) @(negedge clk);
            checkOutput("req_err_count", err_cnt, 1);
            checkOutput("no_tx_bytes", rx_q.size(), 0);
            checkOutput("pkt_valid_idle", 32'(pkt_valid), 0);
            @(posedge clk); #1;
            return;
        end

        for (int i = 0; i < int'(len); i++) begin
            taken = 1'b0;
            if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    pl_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            pl_valid = 1'b1;
            pl_data  = pl_bytes[i];
            for (int c = 0; c < 50 && !taken; c++) begin
                @(negedge clk);
                taken = pl_ready;
                @(posedge clk); #1;
            end
            if (!taken) load_fail++;
        end
        pl_valid = 1'b0;
        checkOutput("payload_load_stalls", load_fail, 0);

        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            if (mode == 3 && pkt_valid && rx_q.size() == 3) begin
                rst = 1'b1;
                #1;
                checkOutput("midpkt_rst_pkt_valid", 32'(pkt_valid), 0);
                checkOutput("midpkt_rst_data_out", 32'(data_out), 0);
                @(negedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                checkOutput("midpkt_rst_req_ready", 32'(req_ready), 1);
                repeat (6) @(posedge clk);
                #1;
                checkOutput("midpkt_rst_no_parity", par_q.size(), 0);
                checkOutput("midpkt_rst_no_done", done_cnt, 0);
                return;
            end
            case (mode)
                1:       busy = pkt_valid && (held < 4);
                2:       busy = ($urandom_range(0, 2) == 0);
                default: busy = 1'b0;
            endcase
            if (mode == 1 && busy) held++;
            @(posedge clk); #1;
        end
        busy = 1'b0;

        if (mode == 3) begin
            checkOutput("midpkt_rst_reached", rx_q.size(), 3);
            return;
        end

        repeat (GAP_CYC + 3) @(posedge clk);
        #1;
        checkOutput("byte_count", rx_q.size(), int'(len) + 1);
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) checkOutput($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
        end
        checkOutput("parity_count", par_q.size(), 1);
        if (par_q.size() > 0) checkOutput("parity", par_q[0], exp_par);
        checkOutput("tx_done_count", done_cnt, 1);
        checkOutput("busy_hold_violations", hold_viol, 0);
        checkOutput("gap_cycles", gap_count, GAP_CYC);
        checkOutput("req_err_quiet", err_cnt, 0);
        if (mode == 1) checkOutput("header_hold_cycles", hdr_cycles, 5);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        pl_valid  = 1'b0;
        pl_data   = '0;
        busy      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pkt_valid", 32'(pkt_valid), 0);
        checkOutput("rst_data_out", 32'(data_out), 0);
        checkOutput("rst_tx_done", 32'(tx_done), 0);
        checkOutput("rst_req_err", 32'(req_err), 0);
        checkOutput("rst_pl_ready", 32'(pl_ready), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 1);

        $display("[TB] basic packet addr=1 len=3");
        pl_bytes[0] = 8'h11;
        pl_bytes[1] = 8'h22;
        pl_bytes[2] = 8'h33;
        applyStimulus(2'd1, 6'd3, 0);

        $display("[TB] header held by busy");
        applyStimulus(2'd1, 6'd3, 1);

        $display("[TB] illegal requests");
        applyStimulus(2'd3, 6'd5, 0);
        applyStimulus(2'd2, 6'd0, 0);

        $display("[TB] max length with random busy");
        for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
        applyStimulus(2'd0, 6'd63, 2);

        $display("[TB] reset in third payload byte, then clean packet");
        for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
        applyStimulus(2'd2, 6'd8, 3);
        for (int i = 0; i < 64; i++) pl_bytes[i] = 8'($urandom);
        applyStimulus(2'd1, 6'd4, 0);

        $display("[TB] single-byte packet with random busy");
        pl_bytes[0] = 8'($urandom);
        applyStimulus(2'd2, 6'd1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
